// File: rtl/fpu_regfile_sb_pkg.sv
// Shared FP register-file package: default geometry and the scoreboard state type.
// Used by fpu_scoreboard and fpu_regfile_sb.
package fpu_regfile_sb_pkg;

    localparam int FP_XLEN   = 32;
    localparam int FP_NREG   = 32;
    localparam int FP_NRPORT = 3;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_PEND = 1'b1
    } sb_state_e;

endpackage

// File: rtl/fpu_scoreboard.sv
// Per-register busy FSMs for long-latency ops plus the combinational issue-stall logic.
// Macro FPU_FWD_EN: a register being written back on the long port this cycle does not cause RAW.
module fpu_scoreboard
    import fpu_regfile_sb_pkg::*;
#(
    parameter int   NREG   = FP_NREG,
    parameter int   NRPORT = FP_NRPORT,
    localparam int  AW     = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRPORT-1:0]    rd_en,
    input  logic [NRPORT*AW-1:0] rd_addr,
    input  logic                 iss_valid,
    input  logic                 iss_long,
    input  logic                 iss_wren,
    input  logic [AW-1:0]        iss_waddr,
    input  logic                 lwr_en,
    input  logic [AW-1:0]        lwr_addr,
    input  logic                 rd_conflict,
    output logic                 stall,
    output logic [NREG-1:0]      busy
);

    sb_state_e state [NREG];
    logic      raw;
    logic      waw;
    logic      set_en;

    always_comb begin
        // NOTE: default every always_comb output before any branch so no latch is inferred.
        raw = 1'b0;
        for (int i = 0; i < NRPORT; i++) begin
            if (rd_en[i] && state[rd_addr[i*AW +: AW]] == SB_PEND) begin
`ifdef FPU_FWD_EN
                if (!(lwr_en && lwr_addr == rd_addr[i*AW +: AW]))
                    raw = 1'b1;
`else
                raw = 1'b1;
`endif
            end
        end
    end

    // A writeback retiring the same register lets a new long op to it issue in that cycle.
    assign waw    = iss_wren && state[iss_waddr] == SB_PEND
                    && !(lwr_en && lwr_addr == iss_waddr);
    assign stall  = !rst && iss_valid && (raw || waw || rd_conflict);
    assign set_en = iss_valid && iss_long && iss_wren && !stall;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            for (int r = 0; r < NREG; r++) state[r] <= SB_IDLE;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (set_en && iss_waddr == AW'(r))
                    state[r] <= SB_PEND;
                else if (lwr_en && lwr_addr == AW'(r))
                    state[r] <= SB_IDLE;
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++) busy[r] = (state[r] == SB_PEND);
    end

endmodule

// File: rtl/fpu_regfile_sb.sv
// FP register file with short and long writeback ports, read bypass and a long-op scoreboard.
// Macro FPU_FWD_EN enables same-cycle bypass; otherwise reads colliding with a writeback stall.
module fpu_regfile_sb
    import fpu_regfile_sb_pkg::*;
#(
    parameter int   XLEN   = FP_XLEN,
    parameter int   NREG   = FP_NREG,
    parameter int   NRPORT = FP_NRPORT,
    localparam int  AW     = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRPORT-1:0]      rd_en,
    input  logic [NRPORT*AW-1:0]   rd_addr,
    output logic [NRPORT*XLEN-1:0] rd_data,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   lwr_en,
    input  logic [AW-1:0]          lwr_addr,
    input  logic [XLEN-1:0]        lwr_data,
    input  logic                   iss_valid,
    input  logic                   iss_long,
    input  logic                   iss_wren,
    input  logic [AW-1:0]          iss_waddr,
    output logic                   stall,
    output logic [NREG-1:0]        busy
);

    logic [XLEN-1:0] mem [NREG];
    logic            rd_conflict;

    always_ff @(posedge clk) begin
        // NOTE: the array is architecturally cleared by reset, so it is reset like any flop.
        if (rst) begin
            for (int r = 0; r < NREG; r++) mem[r] <= '0;
        end else begin
            if (wr_en)  mem[wr_addr]  <= wr_data;
            // Last assignment wins: the long port takes a same-address collision.
            if (lwr_en) mem[lwr_addr] <= lwr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRPORT; i++) begin
            if (rd_en[i]) begin
                rd_data[i*XLEN +: XLEN] = mem[rd_addr[i*AW +: AW]];
`ifdef FPU_FWD_EN
                if (!rst && lwr_en && lwr_addr == rd_addr[i*AW +: AW])
                    rd_data[i*XLEN +: XLEN] = lwr_data;
                else if (!rst && wr_en && wr_addr == rd_addr[i*AW +: AW])
                    rd_data[i*XLEN +: XLEN] = wr_data;
`endif
            end
        end
    end

`ifdef FPU_FWD_EN
    assign rd_conflict = 1'b0;
`else
    always_comb begin
        rd_conflict = 1'b0;
        for (int i = 0; i < NRPORT; i++) begin
            if (rd_en[i] && ((wr_en  && wr_addr  == rd_addr[i*AW +: AW]) ||
                             (lwr_en && lwr_addr == rd_addr[i*AW +: AW])))
                rd_conflict = 1'b1;
        end
    end
`endif

    fpu_scoreboard #(
        .NREG   (NREG),
        .NRPORT (NRPORT)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .iss_valid   (iss_valid),
        .iss_long    (iss_long),
        .iss_wren    (iss_wren),
        .iss_waddr   (iss_waddr),
        .lwr_en      (lwr_en),
        .lwr_addr    (lwr_addr),
        .rd_conflict (rd_conflict),
        .stall       (stall),
        .busy        (busy)
    );

endmodule

// File: tb/tb_fpu_regfile_sb.sv
// Directed bench for fpu_regfile_sb (default geometry); expectations follow FPU_FWD_EN if defined.
module tb_fpu_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 3;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRP-1:0]       rd_en;
    logic [NRP*AW-1:0]    rd_addr;
    logic [NRP*XLEN-1:0]  rd_data;
    logic                 wr_en, lwr_en;
    logic [AW-1:0]        wr_addr, lwr_addr, iss_waddr;
    logic [XLEN-1:0]      wr_data, lwr_data;
    logic                 iss_valid, iss_long, iss_wren;
    logic                 stall;
    logic [NREG-1:0]      busy;

    int n_vec = 0;
    int n_err = 0;

    fpu_regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .lwr_en    (lwr_en),
        .lwr_addr  (lwr_addr),
        .lwr_data  (lwr_data),
        .iss_valid (iss_valid),
        .iss_long  (iss_long),
        .iss_wren  (iss_wren),
        .iss_waddr (iss_waddr),
        .stall     (stall),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        lwr_en = 1'b0; lwr_addr = '0; lwr_data = '0;
        iss_valid = 1'b0; iss_long = 1'b0; iss_wren = 1'b0; iss_waddr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic issue_long(input logic [AW-1:0] a);
        iss_valid = 1'b1; iss_long = 1'b1; iss_wren = 1'b1; iss_waddr = a;
    endtask

    function automatic logic [XLEN-1:0] rdat(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        tick();
        // Reset with a colliding write and read: stall held low, write discarded.
        iss_valid = 1'b1; iss_wren = 1'b1; iss_waddr = 5'd1;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hCAFE0001;
        rd(0, 5'd1);
        #1;
        check("stall_in_rst", stall, 1'b0);
        tick();
        rst = 1'b0;
        idle();

        // Post-reset reads
        rd_en = 3'b111;
        rd_addr = {5'd5, 5'd5, 5'd5};
        #1;
        check("rst_rd0", rdat(0), 32'h0);
        check("rst_rd1", rdat(1), 32'h0);
        check("rst_rd2", rdat(2), 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_stall", stall, 1'b0);
        idle(); rd(0, 5'd1);
        #1;
        check("rst_wr_dropped", rdat(0), 32'h0);

        // Short write to f3 with a same-cycle read
        idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h3F800000;
        iss_valid = 1'b1; rd(0, 5'd3);
        #1;
`ifdef FPU_FWD_EN
        check("wr_byp_data", rdat(0), 32'h3F800000);
        check("wr_byp_stall", stall, 1'b0);
`else
        check("wr_nobyp_data", rdat(0), 32'h0);
        check("wr_nobyp_stall", stall, 1'b1);
`endif
        tick();
        idle(); rd(1, 5'd3);
        #1;
        check("wr_f3_read", rdat(1), 32'h3F800000);
        rd_en = 3'b011; rd_addr[2*AW +: AW] = 5'd3;
        #1;
        check("rd_disabled", rdat(2), 32'h0);

        // Long op to f7, RAW stall until writeback
        idle(); issue_long(5'd7);
        #1;
        check("iss_f7_stall", stall, 1'b0);
        tick();
        idle();
        #1;
        check("busy_f7", busy, 32'h0000_0080);
        rd(0, 5'd7);
        #1;
        check("raw_no_valid", stall, 1'b0);
        iss_valid = 1'b1;
        #1;
        check("raw_f7_c0", stall, 1'b1);
        tick();
        check("raw_f7_c1", stall, 1'b1);
        check("busy_f7_hold", busy, 32'h0000_0080);
        lwr_en = 1'b1; lwr_addr = 5'd7; lwr_data = 32'h40490FDB;
        #1;
`ifdef FPU_FWD_EN
        check("lwr_f7_stall", stall, 1'b0);
        check("lwr_f7_byp", rdat(0), 32'h40490FDB);
`else
        check("lwr_f7_stall", stall, 1'b1);
        check("lwr_f7_nobyp", rdat(0), 32'h0);
`endif
        tick();
        lwr_en = 1'b0;
        #1;
        check("f7_busy_clr", busy, 32'h0);
        check("f7_stall_clr", stall, 1'b0);
        check("f7_read", rdat(0), 32'h40490FDB);

        // WAW on f2 and set-wins-over-clear
        idle(); issue_long(5'd2);
        tick();
        idle();
        #1;
        check("busy_f2", busy, 32'h0000_0004);
        iss_valid = 1'b1; iss_wren = 1'b1; iss_waddr = 5'd2;
        #1;
        check("waw_f2", stall, 1'b1);
        tick();
        check("waw_f2_busy", busy, 32'h0000_0004);
        idle(); issue_long(5'd2);
        lwr_en = 1'b1; lwr_addr = 5'd2; lwr_data = 32'h12345678;
        #1;
        check("set_clr_stall", stall, 1'b0);
        tick();
        idle();
        #1;
        check("set_wins", busy, 32'h0000_0004);
        lwr_en = 1'b1; lwr_addr = 5'd2; lwr_data = 32'h87654321;
        tick();
        idle(); rd(0, 5'd2);
        #1;
        check("f2_busy_clr", busy, 32'h0);
        check("f2_read", rdat(0), 32'h87654321);

        // Write-port collisions
        idle();
        wr_en = 1'b1;  wr_addr = 5'd9;  wr_data = 32'h11111111;
        lwr_en = 1'b1; lwr_addr = 5'd9; lwr_data = 32'h22222222;
`ifdef FPU_FWD_EN
        rd(2, 5'd9);
        #1;
        check("f9_byp_prio", rdat(2), 32'h22222222);
`endif
        tick();
        idle(); rd(2, 5'd9);
        #1;
        check("f9_lwr_wins", rdat(2), 32'h22222222);
        wr_en = 1'b1;  wr_addr = 5'd10; wr_data = 32'hAAAA0010;
        lwr_en = 1'b1; lwr_addr = 5'd11; lwr_data = 32'hBBBB0011;
        rd_en = '0;
        tick();
        idle(); rd(0, 5'd10); rd(1, 5'd11);
        #1;
        check("f10_read", rdat(0), 32'hAAAA0010);
        check("f11_read", rdat(1), 32'hBBBB0011);

        // Reset while a long op is pending on f4
        idle();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55555555;
        tick();
        idle(); issue_long(5'd4);
        tick();
        idle();
        #1;
        check("busy_f4", busy, 32'h0000_0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(0, 5'd4); rd(1, 5'd3);
        #1;
        check("rst2_busy", busy, 32'h0);
        check("rst2_f4", rdat(0), 32'h0);
        check("rst2_f3", rdat(1), 32'h0);
        idle();
        lwr_en = 1'b1; lwr_addr = 5'd4; lwr_data = 32'hDEADBEEF;
        tick();
        idle(); rd(0, 5'd4);
        #1;
        check("f4_late_lwr", rdat(0), 32'hDEADBEEF);
        check("f4_busy_stays0", busy, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
